// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for the sequential ALU.
//   master : drives start, A, B, ALUop, ALUbank, Cin; observes busy, done,
//            result, flags
//   slave  : the ALU side of the same signals
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUop;
  logic             ALUbank;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, A, B, ALUop, ALUbank, Cin,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, A, B, ALUop, ALUbank, Cin,
    output busy, done, result, flags
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: ALU with single-cycle ops (BCD add/sub, logic, add/sub, pass)
// and iterative shift-add multiply / restoring divide.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seq_alu_if slave (start/operands in, busy/done/result/flags out)
// flags = {N, Z, V, C}. op = {ALUbank, ALUop}.
//
// state  | meaning
// S_IDLE | ready; accepts start
// S_MUL  | shift-add multiply, one step per cycle, then finish
// S_DIV  | restoring divide, one step per cycle, then finish
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     reset,
  seq_alu_if.slave bus
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t state, state_nxt;

  logic [3:0]       op_in;
  logic             iter_in;
  logic             accept;
  logic             finish;
  logic [WIDTH-1:0] a_q, b_q, acc_hi, acc_lo, result_q;
  logic [3:0]       op_q, flags_q;
  logic             cin_q, pend, done_q;
  logic [CW-1:0]    count;

  assign op_in   = {bus.ALUbank, bus.ALUop};
  assign iter_in = (op_in[3:2] == 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        accept = bus.start;
        if (bus.start && iter_in) state_nxt = op_in[1] ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: begin
        // count reaches zero after WIDTH steps; the next edge writes the result
        if (count == '0) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // single-cycle datapath, evaluated from the operands captured at accept
  logic [WIDTH:0]      add_u, sub_u;
  logic [WIDTH-1:0]    bcd_add, bcd_sub, alu_res;
  logic                bcd_add_c, bcd_sub_c, alu_c, alu_v, alu_n;
  logic [4:0]          dsum;
  logic signed [5:0]   ddiff;
  logic [3:0]          alu_flags;

  always_comb begin
    add_u = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    sub_u = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};

    bcd_add   = '0;
    bcd_sub   = '0;
    bcd_add_c = cin_q;
    bcd_sub_c = cin_q;
    dsum      = '0;
    ddiff     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, a_q[4*i +: 4]} + {1'b0, b_q[4*i +: 4]} + {4'b0000, bcd_add_c};
      if (dsum > 5'd9) begin
        dsum      = dsum - 5'd10;
        bcd_add_c = 1'b1;
      end else begin
        bcd_add_c = 1'b0;
      end
      bcd_add[4*i +: 4] = dsum[3:0];

      ddiff = $signed({2'b00, a_q[4*i +: 4]}) - $signed({2'b00, b_q[4*i +: 4]})
              - $signed({5'b00000, bcd_sub_c});
      if (ddiff < 6'sd0) begin
        ddiff     = ddiff + 6'sd10;
        bcd_sub_c = 1'b1;
      end else begin
        bcd_sub_c = 1'b0;
      end
      bcd_sub[4*i +: 4] = ddiff[3:0];
    end

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      4'h0: begin alu_res = bcd_add; alu_c = bcd_add_c; end
      4'h1: begin alu_res = bcd_sub; alu_c = bcd_sub_c; end
      4'h2: alu_res = a_q & b_q;
      4'h3: alu_res = a_q | b_q;
      4'h4: alu_res = a_q ^ b_q;
      4'h5: begin
        alu_res = a_q + WIDTH'(1);
        alu_c   = &a_q;
        alu_v   = (a_q == {1'b0, {(WIDTH-1){1'b1}}});
      end
      4'h8: begin
        alu_res = add_u[WIDTH-1:0];
        alu_c   = add_u[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_u[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h9: begin
        // bit WIDTH of the extended difference is the borrow
        alu_res = sub_u[WIDTH-1:0];
        alu_c   = sub_u[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_u[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'hA: alu_res = a_q;
      4'hB: alu_res = b_q;
      default: alu_res = '0;
    endcase

    alu_n     = (op_q[3:1] == 3'b000) ? 1'b0 : alu_res[WIDTH-1];
    alu_flags = {alu_n, (alu_res == '0), alu_v, alu_c};
    if (op_q == 4'h6) alu_flags = b_q[3:0];
  end

  // iterative datapath: {acc_hi, acc_lo} is the product register for MUL
  // (multiplier in acc_lo) and {remainder, quotient} for DIV
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_sub, iter_res;
  logic             div_ge, iter_v;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_sub  = div_sh[WIDTH-1:0] - b_q;
  assign iter_res = op_q[0] ? acc_hi : acc_lo;
  assign iter_v   = op_q[1] && (b_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      pend     <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      count    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend   <= accept && !iter_in;
      if (accept) begin
        a_q   <= bus.A;
        b_q   <= bus.B;
        op_q  <= op_in;
        cin_q <= bus.Cin;
        if (iter_in) begin
          acc_hi <= '0;
          acc_lo <= op_in[1] ? bus.A : bus.B;
          count  <= CW'(WIDTH);
        end
      end
      if (pend) begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
        done_q   <= 1'b1;
      end
      if (state == S_MUL && count != '0) begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        count  <= count - CW'(1);
      end
      if (state == S_DIV && count != '0) begin
        acc_hi <= div_ge ? div_sub : div_sh[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
        count  <= count - CW'(1);
      end
      if (finish) begin
        result_q <= iter_res;
        flags_q  <= {iter_res[WIDTH-1], (iter_res == '0), iter_v, 1'b0};
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Port clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  request; sampled only while busy=0.
REQ-005 Port A  input  WIDTH  first operand.
REQ-006 Port B  input  WIDTH  second operand.
REQ-007 Port ALUop  input  3  operation within bank.
REQ-008 Port ALUbank  input  1  bank select; op = {ALUbank, ALUop}.
REQ-009 Port Cin  input  1  carry/borrow in.
REQ-010 Port busy  output  1  high while an iterative operation is in progress.
REQ-011 Port done  output  1  one-cycle pulse; result and flags are valid.
REQ-012 Port result  output  WIDTH  registered result.
REQ-013 Port flags  output  4  registered {N,Z,V,C}.

Function
REQ-014 Op encoding SHALL be: 0 DADD, 1 DSUB, 2 AND, 3 OR, 4 XOR, 5 INCA, 6 BFLAGS, 7 ZERO, 8 ADD, 9 SUB, A PASSA, B PASSB, C MULLO, D MULHI, E DIV, F MOD.
REQ-015 When start=1 and busy=0 at an edge, A, B, op and Cin SHALL be captured; inputs are ignored afterwards until the next accept.
REQ-016 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-017 Ops 0-B SHALL complete in one cycle: done=1, result and flags updated on the edge after the accepting edge; busy stays 0.
REQ-018 Ops C-F SHALL use a state machine IDLE -> MUL or DIV -> IDLE, one shift-add/shift-subtract step per cycle, for WIDTH steps.
REQ-019 For ops C-F, busy SHALL be 1 from the edge after acceptance, and done SHALL pulse and busy SHALL fall on the same edge, exactly WIDTH+1 edges after the accepting edge.
REQ-020 A new start SHALL be accepted in the same cycle that done=1.
REQ-021 result and flags SHALL hold their values between done pulses.
REQ-022 ADD: A+B+Cin modulo 2^WIDTH; C = carry out; V = signed overflow of the two's-complement add.
REQ-023 SUB: A-B-Cin; C = 1 on borrow (unsigned A < B+Cin); V = signed overflow of the subtract.
REQ-024 DADD/DSUB: per-digit BCD over WIDTH/4 digits, Cin into digit 0, carry/borrow rippled upward; digit result >9 corrected by -10 (add) or negative by +10 (sub), then truncated to 4 bits; C = final digit carry/borrow; N=0, V=0.
REQ-025 AND/OR/XOR/PASSA/PASSB: bitwise result; C=0, V=0.
REQ-026 INCA: A+1; C = carry out; V = 1 only when A = 0111...1.
REQ-027 BFLAGS: result 0; flags = B[3:0]. ZERO: result 0; flags = 0100.
REQ-028 MULLO/MULHI: unsigned 2*WIDTH product; low/high WIDTH bits; C=0, V=0.
REQ-029 DIV/MOD: unsigned quotient/remainder; C=0, V=0.
REQ-030 B=0 for DIV/MOD: quotient all ones, remainder = A, V=1; latency unchanged.
REQ-031 Except REQ-024/027, N = result[WIDTH-1]; Z = (result == 0) for all ops except BFLAGS.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, busy=0, done=0, result=0, flags=0000, step counter=0.
REQ-033 reset during an iterative op SHALL abort it with no done pulse; the first edge after release SHALL accept start normally.

Verification (WIDTH=8)
REQ-034 ADD A=7F B=01 Cin=0 -> next cycle done=1, result=80, flags N=1 Z=0 V=1 C=0.
REQ-035 DADD A=58 B=67 Cin=0 -> result=25, C=1; DSUB A=10 B=01 -> result=09, C=0.
REQ-036 MULHI A=FF B=FF -> done exactly 9 edges after accept, result=FE; MULLO same operands -> 01.
REQ-037 DIV A=2A B=00 -> result=FF, V=1; MOD A=2A B=05 -> result=02, Z=0.
REQ-038 start MULLO, then assert start with SUB at step 3 -> ignored; single done with product; then reset at step 4 of a DIV -> busy=0 at once, no done, outputs zero.
